// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a registered 2:1 mux with fair tie-breaking.
// Define MUX_ARB_TIMEOUT_EN to force a handover after MAX_HOLD grant cycles.
module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic a,
    input  logic b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic y,
    output logic y_valid
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_b;
    logic       last_b_nxt;
    logic       sel_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic       at_limit;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("mux_arbiter: MAX_HOLD must be 2..255");
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    assign at_limit = (hold_cnt == HOLD_LAST);
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_a && (!req_b || last_b))
                    state_nxt = GRANT_A;
                else if (req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (!req_a)
                    state_nxt = req_b ? GRANT_B : IDLE;
                else if (at_limit && req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_B: begin
                if (!req_b)
                    state_nxt = req_a ? GRANT_A : IDLE;
                else if (at_limit && req_a)
                    state_nxt = GRANT_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_nxt    = sel;
        last_b_nxt = last_b;
        if (state_nxt != IDLE) begin
            sel_nxt    = (state_nxt == GRANT_B);
            last_b_nxt = (state_nxt == GRANT_B);
        end
    end

    // At the limit with nobody waiting, the owner restarts its hold window.
    always_comb begin
        hold_nxt = hold_cnt;
        if (state_nxt == IDLE || state_nxt != state)
            hold_nxt = 8'd0;
        else if (at_limit)
            hold_nxt = 8'd0;
        else if (hold_cnt != 8'hff)
            hold_nxt = hold_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last_b   <= 1'b1;
            hold_cnt <= 8'd0;
            y        <= 1'b0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            last_b   <= last_b_nxt;
            hold_cnt <= hold_nxt;
            y        <= sel ? b : a;
            y_valid  <= gnt_a | gnt_b;
        end
    end

    assign gnt_a = (state == GRANT_A);
    assign gnt_b = (state == GRANT_B);

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed vector table,
// tie/timeout sequence, glitch check and random run against a model.
module tb_mux_arbiter;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst, req_a, req_b, a, b;
    logic gnt_a, gnt_b, sel, y, y_valid;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(.MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .req_b  (req_b),
        .a      (a),
        .b      (b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .sel    (sel),
        .y      (y),
        .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst, ra, rb, a, b;
        logic ga, gb, sel, y, yv;
    } vec_t;

    vec_t vecs[20];

    // Reference model: owner 0=none 1=A 2=B
    int   m_own, m_last, m_hold;
    logic m_sel, m_y, m_yv;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, ra, rb, aa, bb);
        rst = r; req_a = ra; req_b = rb; a = aa; b = bb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_step(input logic r, ra, rb, aa, bb);
        int nxt, oth;
        logic own_req, oth_req, tmo;
        if (r) begin
            m_own = 0; m_last = 2; m_hold = 0;
            m_sel = 0; m_y = 0; m_yv = 0;
            return;
        end
        m_yv = (m_own != 0);
        m_y  = m_sel ? bb : aa;
`ifdef MUX_ARB_TIMEOUT_EN
        tmo = (m_own != 0) && (m_hold == MH - 1);
`else
        tmo = 1'b0;
`endif
        if (m_own == 0) begin
            if (ra && rb) nxt = (m_last == 1) ? 2 : 1;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
            else          nxt = 0;
        end else begin
            oth     = 3 - m_own;
            own_req = (m_own == 1) ? ra : rb;
            oth_req = (oth == 1) ? ra : rb;
            if (!own_req)            nxt = oth_req ? oth : 0;
            else if (tmo && oth_req) nxt = oth;
            else                     nxt = m_own;
        end
        if (nxt == 0 || nxt != m_own) m_hold = 0;
        else if (tmo)                 m_hold = 0;
        else if (m_hold < 255)        m_hold = m_hold + 1;
        if (nxt != 0) begin
            m_sel  = (nxt == 2);
            m_last = nxt;
        end
        m_own = nxt;
    endtask

    initial begin
        drive(1, 1, 1, 1, 1);
        //          rst ra rb a b   ga gb sel y yv
        vecs[0]  = '{1, 1, 1, 1, 1,  0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 1, 1,  0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 1, 1,  1, 0, 0, 1, 0};
        vecs[3]  = '{0, 1, 0, 0, 0,  1, 0, 0, 0, 1};
        vecs[4]  = '{0, 1, 0, 1, 0,  1, 0, 0, 1, 1};
        vecs[5]  = '{0, 1, 0, 0, 0,  1, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 1, 1, 0,  0, 1, 1, 1, 1};
        vecs[7]  = '{0, 0, 1, 0, 1,  0, 1, 1, 1, 1};
        vecs[8]  = '{0, 0, 1, 1, 0,  0, 1, 1, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 1,  0, 0, 1, 1, 1};
        vecs[10] = '{0, 0, 0, 0, 1,  0, 0, 1, 1, 0};
        vecs[11] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1,  0, 0, 1, 1, 0};
        vecs[13] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0};
        vecs[14] = '{0, 0, 1, 0, 1,  0, 1, 1, 1, 0};
        vecs[15] = '{1, 1, 1, 1, 1,  0, 0, 0, 0, 0};
        vecs[16] = '{0, 1, 1, 0, 1,  1, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        vecs[18] = '{0, 1, 1, 1, 0,  0, 1, 1, 1, 0};
        vecs[19] = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].a, vecs[i].b);
            step();
            chk($sformatf("vec%0d gnt_a", i), gnt_a, vecs[i].ga);
            chk($sformatf("vec%0d gnt_b", i), gnt_b, vecs[i].gb);
            chk($sformatf("vec%0d sel", i), sel, vecs[i].sel);
            chk($sformatf("vec%0d y", i), y, vecs[i].y);
            chk($sformatf("vec%0d y_valid", i), y_valid, vecs[i].yv);
        end

        // Request glitch between edges must not be seen
        drive(0, 1, 0, 0, 0);
        #2;
        drive(0, 0, 0, 0, 0);
        step();
        chk("glitch gnt_a", gnt_a, 1'b0);

        // Sustained tie: alternation only with the timeout compiled in
        drive(1, 1, 1, 0, 0);
        step();
        drive(0, 1, 1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            logic exp_a;
`ifdef MUX_ARB_TIMEOUT_EN
            exp_a = ((k / MH) % 2) == 0;
`else
            exp_a = 1'b1;
`endif
            step();
            chk($sformatf("tie%0d gnt_a", k), gnt_a, exp_a);
            chk($sformatf("tie%0d gnt_b", k), gnt_b, !exp_a);
        end

        // Random run against the model
        drive(1, 0, 0, 0, 0);
        step();
        m_step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, ra, rb, aa, bb;
            r  = ($urandom_range(63) == 0);
            ra = ($urandom_range(3) != 0);
            rb = ($urandom_range(3) != 0);
            aa = 1'($urandom_range(1));
            bb = 1'($urandom_range(1));
            drive(r, ra, rb, aa, bb);
            step();
            m_step(r, ra, rb, aa, bb);
            chk("rnd gnt_a", gnt_a, m_own == 1);
            chk("rnd gnt_b", gnt_b, m_own == 2);
            chk("rnd sel", sel, m_sel);
            chk("rnd y", y, m_y);
            chk("rnd y_valid", y_valid, m_yv);
            chk("rnd excl", gnt_a & gnt_b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
